// File: rtl/id_issue_stage.sv
// MIPS decode/issue stage: combinational decode with operand bypass and load-use
// hazard detection, feeding a valid/ready ID/EX register.
module id_issue_stage #(
   parameter int DATA_W = 32,
   parameter int NFWD   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            inst_i,
   input  logic [31:0]            pc_i,
   output logic [4:0]             rf_raddr1,
   output logic [4:0]             rf_raddr2,
   input  logic [DATA_W-1:0]      rf_rdata1,
   input  logic [DATA_W-1:0]      rf_rdata2,
   input  logic [NFWD-1:0]        fwd_we,
   input  logic [5*NFWD-1:0]      fwd_waddr,
   input  logic [DATA_W*NFWD-1:0] fwd_wdata,
   input  logic [NFWD-1:0]        fwd_pending,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             aluop_o,
   output logic [2:0]             alusel_o,
   output logic [DATA_W-1:0]      reg1_o,
   output logic [DATA_W-1:0]      reg2_o,
   output logic [4:0]             wd_o,
   output logic                   wreg_o,
   output logic [31:0]            pc_o,
   output logic                   invalid_o,
   output logic [15:0]            stall_cnt_o
);

   localparam logic [7:0] ALU_NOP = 8'h00, ALU_AND = 8'h24, ALU_OR  = 8'h25,
                          ALU_XOR = 8'h26, ALU_NOR = 8'h27, ALU_LUI = 8'h5C,
                          ALU_SLL = 8'h7C, ALU_SRL = 8'h02, ALU_SRA = 8'h03;
   localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm;

   assign op    = inst_i[31:26];
   assign rs    = inst_i[25:21];
   assign rt    = inst_i[20:16];
   assign rd    = inst_i[15:11];
   assign sa    = inst_i[10:6];
   assign funct = inst_i[5:0];
   assign imm   = inst_i[15:0];

   assign rf_raddr1 = rs;
   assign rf_raddr2 = rt;

   // Returns {pending, data}; index 0 is applied last so it wins, and $0 overrides all.
   function automatic logic [DATA_W:0] resolve(
      input logic [4:0]             addr,
      input logic [DATA_W-1:0]      rf_val,
      input logic [NFWD-1:0]        we,
      input logic [5*NFWD-1:0]      waddr,
      input logic [DATA_W*NFWD-1:0] wdata,
      input logic [NFWD-1:0]        pend
   );
      logic [DATA_W:0] r;
      r = {1'b0, rf_val};
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (we[i] && waddr[5*i +: 5] == addr)
            r = {pend[i], wdata[DATA_W*i +: DATA_W]};
      end
      if (addr == 5'd0)
         r = '0;
      return r;
   endfunction

   logic [DATA_W:0]   opnd1, opnd2;
   logic              use_rs, use_rt, hazard, accept;
   logic [7:0]        dec_aluop;
   logic [2:0]        dec_alusel;
   logic [DATA_W-1:0] dec_reg1, dec_reg2;
   logic [4:0]        dec_wd;
   logic              dec_wreg, dec_invalid;

   always_comb begin
      opnd1 = resolve(rs, rf_rdata1, fwd_we, fwd_waddr, fwd_wdata, fwd_pending);
      opnd2 = resolve(rt, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata, fwd_pending);
   end

   always_comb begin
      dec_aluop   = ALU_NOP;
      dec_alusel  = SEL_NOP;
      dec_reg1    = '0;
      dec_reg2    = '0;
      dec_wd      = 5'd0;
      dec_wreg    = 1'b0;
      dec_invalid = 1'b0;
      use_rs      = 1'b0;
      use_rt      = 1'b0;
      if (op == 6'h00 && inst_i[25:21] == 5'd0 &&
          (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)) begin
         // Immediate shifts: shamt travels as operand 1
         dec_alusel = SEL_SHIFT;
         dec_aluop  = (funct == 6'h00) ? ALU_SLL : (funct == 6'h02) ? ALU_SRL : ALU_SRA;
         dec_reg1   = DATA_W'(sa);
         dec_reg2   = opnd2[DATA_W-1:0];
         dec_wd     = rd;
         dec_wreg   = 1'b1;
         use_rt     = 1'b1;
      end else if (op == 6'h00 && sa == 5'd0) begin
         dec_reg1 = opnd1[DATA_W-1:0];
         dec_reg2 = opnd2[DATA_W-1:0];
         dec_wd   = rd;
         dec_wreg = 1'b1;
         use_rs   = 1'b1;
         use_rt   = 1'b1;
         case (funct)
            6'h24:   begin dec_aluop = ALU_AND; dec_alusel = SEL_LOGIC; end
            6'h25:   begin dec_aluop = ALU_OR;  dec_alusel = SEL_LOGIC; end
            6'h26:   begin dec_aluop = ALU_XOR; dec_alusel = SEL_LOGIC; end
            6'h27:   begin dec_aluop = ALU_NOR; dec_alusel = SEL_LOGIC; end
            6'h04:   begin dec_aluop = ALU_SLL; dec_alusel = SEL_SHIFT; end
            6'h06:   begin dec_aluop = ALU_SRL; dec_alusel = SEL_SHIFT; end
            6'h07:   begin dec_aluop = ALU_SRA; dec_alusel = SEL_SHIFT; end
            default: begin
               dec_reg1    = '0;
               dec_reg2    = '0;
               dec_wd      = 5'd0;
               dec_wreg    = 1'b0;
               use_rs      = 1'b0;
               use_rt      = 1'b0;
               dec_invalid = (funct != 6'h0F);
            end
         endcase
      end else begin
         case (op)
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
               dec_alusel = SEL_LOGIC;
               dec_aluop  = (op == 6'h0C) ? ALU_AND : (op == 6'h0D) ? ALU_OR :
                            (op == 6'h0E) ? ALU_XOR : ALU_LUI;
               dec_reg1   = opnd1[DATA_W-1:0];
               dec_reg2   = (op == 6'h0F) ? DATA_W'({imm, 16'h0000}) : DATA_W'(imm);
               dec_wd     = rt;
               dec_wreg   = 1'b1;
               use_rs     = 1'b1;
            end
            6'h33:   ;
            default: dec_invalid = 1'b1;
         endcase
      end
   end

   assign hazard   = (use_rs && opnd1[DATA_W]) || (use_rt && opnd2[DATA_W]);
   assign in_ready = (!out_valid || out_ready) && !hazard && !rst;
   assign accept   = in_valid && in_ready;

   logic              out_valid_q, out_valid_d;
   logic [7:0]        aluop_q, aluop_d;
   logic [2:0]        alusel_q, alusel_d;
   logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
   logic [4:0]        wd_q, wd_d;
   logic              wreg_q, wreg_d, invalid_q, invalid_d;
   logic [31:0]       pc_q, pc_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;

   always_comb begin
      out_valid_d = out_valid_q;
      aluop_d     = aluop_q;
      alusel_d    = alusel_q;
      reg1_d      = reg1_q;
      reg2_d      = reg2_q;
      wd_d        = wd_q;
      wreg_d      = wreg_q;
      invalid_d   = invalid_q;
      pc_d        = pc_q;
      stall_cnt_d = stall_cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         aluop_d     = dec_aluop;
         alusel_d    = dec_alusel;
         reg1_d      = dec_reg1;
         reg2_d      = dec_reg2;
         wd_d        = dec_wd;
         wreg_d      = dec_wreg;
         invalid_d   = dec_invalid;
         pc_d        = pc_i;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (in_valid && hazard && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         aluop_q     <= '0;
         alusel_q    <= '0;
         reg1_q      <= '0;
         reg2_q      <= '0;
         wd_q        <= '0;
         wreg_q      <= 1'b0;
         invalid_q   <= 1'b0;
         pc_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         aluop_q     <= aluop_d;
         alusel_q    <= alusel_d;
         reg1_q      <= reg1_d;
         reg2_q      <= reg2_d;
         wd_q        <= wd_d;
         wreg_q      <= wreg_d;
         invalid_q   <= invalid_d;
         pc_q        <= pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign aluop_o     = aluop_q;
   assign alusel_o    = alusel_q;
   assign reg1_o      = reg1_q;
   assign reg2_o      = reg2_q;
   assign wd_o        = wd_q;
   assign wreg_o      = wreg_q;
   assign invalid_o   = invalid_q;
   assign pc_o        = pc_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: decode, bypass priority, hazard stall,
// backpressure and reset behaviour with hand-computed expectations.
module tb_id_issue_stage;

   localparam int DATA_W = 32;
   localparam int NFWD   = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [31:0]            inst_i;
   logic [31:0]            pc_i;
   logic [4:0]             rf_raddr1, rf_raddr2;
   logic [DATA_W-1:0]      rf_rdata1, rf_rdata2;
   logic [NFWD-1:0]        fwd_we;
   logic [5*NFWD-1:0]      fwd_waddr;
   logic [DATA_W*NFWD-1:0] fwd_wdata;
   logic [NFWD-1:0]        fwd_pending;
   logic                   out_valid;
   logic                   out_ready;
   logic [7:0]             aluop_o;
   logic [2:0]             alusel_o;
   logic [DATA_W-1:0]      reg1_o, reg2_o;
   logic [4:0]             wd_o;
   logic                   wreg_o;
   logic [31:0]            pc_o;
   logic                   invalid_o;
   logic [15:0]            stall_cnt_o;

   logic [31:0] rf [32];
   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   id_issue_stage #(.DATA_W(DATA_W), .NFWD(NFWD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .inst_i(inst_i), .pc_i(pc_i), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we),
      .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
      .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop_o),
      .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o),
      .wreg_o(wreg_o), .pc_o(pc_o), .invalid_o(invalid_o), .stall_cnt_o(stall_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_fwd(input int idx, input logic we, input logic [4:0] addr,
                          input logic [31:0] data, input logic pend);
      fwd_we[idx]                 = we;
      fwd_waddr[5*idx +: 5]       = addr;
      fwd_wdata[DATA_W*idx +: DATA_W] = data;
      fwd_pending[idx]            = pend;
   endtask

   task automatic clr_fwd();
      fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_pending = '0;
   endtask

   task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1'b1; inst_i = inst; pc_i = pc;
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sa, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h01010101 * i;
      rf[1] = 32'h12340000; rf[2] = 32'h22222222; rf[3] = 32'h33333333; rf[7] = 32'h77777777;
      rst = 1'b1; out_ready = 1'b1; clr_fwd();
      offer(itype(6'h0D, 5'd1, 5'd3, 16'h00F0), 32'h0000_0004);

      // reset: in_ready low, everything cleared
      @(negedge clk); #1;
      chk("rst_in_ready", in_ready, 1'b0);
      step();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_stall", stall_cnt_o, 16'h0);
      chk("rst_aluop", aluop_o, 8'h00);
      chk("rst_reg1", reg1_o, 32'h0);
      chk("rst_wreg", wreg_o, 1'b0);
      chk("rst_invalid", invalid_o, 1'b0);
      chk("rst_pc", pc_o, 32'h0);

      // ORI $3,$1,0xF0; pending bypass on the unread rt field must not stall
      rst = 1'b0;
      offer(itype(6'h0D, 5'd1, 5'd3, 16'h00F0), 32'h0000_0100);
      set_fwd(0, 1'b1, 5'd3, 32'hDEAD, 1'b1);
      #1 chk("ori_in_ready", in_ready, 1'b1);
      step();
      chk("ori_valid", out_valid, 1'b1);
      chk("ori_aluop", aluop_o, 8'h25);
      chk("ori_alusel", alusel_o, 3'b001);
      chk("ori_reg1", reg1_o, 32'h12340000);
      chk("ori_reg2", reg2_o, 32'h000000F0);
      chk("ori_wd", wd_o, 5'd3);
      chk("ori_wreg", wreg_o, 1'b1);
      chk("ori_pc", pc_o, 32'h100);
      chk("ori_stall", stall_cnt_o, 16'h0);

      // OR $5,$1,$2: fwd0 beats fwd1; pending on fwd1 ignored
      clr_fwd();
      set_fwd(0, 1'b1, 5'd1, 32'hAAAA, 1'b0);
      set_fwd(1, 1'b1, 5'd1, 32'hBBBB, 1'b1);
      offer(rtype(5'd1, 5'd2, 5'd5, 5'd0, 6'h25), 32'h104);
      #1 chk("or_in_ready", in_ready, 1'b1);
      step();
      chk("or_reg1_fwd0", reg1_o, 32'hAAAA);
      chk("or_reg2", reg2_o, 32'h22222222);
      chk("or_wd", wd_o, 5'd5);

      // $0 read ignores a bypass to address 0
      clr_fwd();
      set_fwd(0, 1'b1, 5'd0, 32'h55, 1'b0);
      offer(rtype(5'd0, 5'd2, 5'd5, 5'd0, 6'h25), 32'h108);
      step();
      chk("or_r0_reg1", reg1_o, 32'h0);

      // AND $4,$2,$3 with pending bypass on $3 for three cycles
      clr_fwd();
      set_fwd(0, 1'b1, 5'd3, 32'hCC, 1'b1);
      offer(rtype(5'd2, 5'd3, 5'd4, 5'd0, 6'h24), 32'h10C);
      for (int i = 0; i < 3; i++) begin
         #1 chk("haz_in_ready", in_ready, 1'b0);
         step();
         if (i == 0) chk("haz_drain", out_valid, 1'b0);
      end
      chk("haz_stall_cnt", stall_cnt_o, 16'd3);
      fwd_pending[0] = 1'b0;
      #1 chk("haz_release_ready", in_ready, 1'b1);
      step();
      chk("haz_acc_valid", out_valid, 1'b1);
      chk("haz_acc_aluop", aluop_o, 8'h24);
      chk("haz_acc_reg1", reg1_o, 32'h22222222);
      chk("haz_acc_reg2", reg2_o, 32'hCC);
      chk("haz_acc_wd", wd_o, 5'd4);
      chk("haz_stall_hold", stall_cnt_o, 16'd3);

      // undecodable word
      clr_fwd();
      offer(32'hFC000000, 32'h110);
      step();
      chk("inv_valid", out_valid, 1'b1);
      chk("inv_invalid", invalid_o, 1'b1);
      chk("inv_wreg", wreg_o, 1'b0);
      chk("inv_aluop", aluop_o, 8'h00);

      // SLL $2,$7,4
      offer(rtype(5'd0, 5'd7, 5'd2, 5'd4, 6'h00), 32'h114);
      step();
      chk("sll_invalid", invalid_o, 1'b0);
      chk("sll_reg1", reg1_o, 32'd4);
      chk("sll_reg2", reg2_o, 32'h77777777);
      chk("sll_aluop", aluop_o, 8'h7C);
      chk("sll_alusel", alusel_o, 3'b010);
      chk("sll_wd", wd_o, 5'd2);

      // backpressure: A = XORI $6,$2,0x1234, B = NOR $8,$1,$2
      offer(itype(6'h0E, 5'd2, 5'd6, 16'h1234), 32'h200);
      step();
      out_ready = 1'b0;
      offer(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h27), 32'h204);
      for (int i = 0; i < 2; i++) begin
         #1 chk("bp_in_ready", in_ready, 1'b0);
         step();
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_pc", pc_o, 32'h200);
         chk("bp_hold_reg2", reg2_o, 32'h1234);
         chk("bp_hold_aluop", aluop_o, 8'h26);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", in_ready, 1'b1);
      step();
      chk("bp_b_pc", pc_o, 32'h204);
      chk("bp_b_aluop", aluop_o, 8'h27);
      chk("bp_b_reg1", reg1_o, 32'h12340000);
      chk("bp_b_wd", wd_o, 5'd8);
      in_valid = 1'b0;
      step();
      chk("bp_no_dup", out_valid, 1'b0);

      // LUI, SRAV, SYNC, PREF
      offer(itype(6'h0F, 5'd0, 5'd9, 16'hABCD), 32'h300);
      step();
      chk("lui_aluop", aluop_o, 8'h5C);
      chk("lui_reg2", reg2_o, 32'hABCD0000);
      chk("lui_wd", wd_o, 5'd9);
      offer(rtype(5'd1, 5'd3, 5'd10, 5'd0, 6'h07), 32'h304);
      step();
      chk("srav_aluop", aluop_o, 8'h03);
      chk("srav_reg1", reg1_o, 32'h12340000);
      chk("srav_reg2", reg2_o, 32'h33333333);
      offer(32'h0000000F, 32'h308);
      step();
      chk("sync_wreg", wreg_o, 1'b0);
      chk("sync_invalid", invalid_o, 1'b0);
      chk("sync_aluop", aluop_o, 8'h00);
      offer(itype(6'h33, 5'd1, 5'd2, 16'h0), 32'h30C);
      step();
      chk("pref_invalid", invalid_o, 1'b0);
      chk("pref_wreg", wreg_o, 1'b0);
      chk("pref_valid", out_valid, 1'b1);

      // reset while full and stalled
      offer(itype(6'h0D, 5'd1, 5'd3, 16'h0001), 32'h400);
      step();
      out_ready = 1'b0;
      set_fwd(0, 1'b1, 5'd2, 32'h1, 1'b1);
      offer(rtype(5'd2, 5'd3, 5'd4, 5'd0, 6'h24), 32'h404);
      step();
      step();
      chk("pre_rst_valid", out_valid, 1'b1);
      chk("pre_rst_stall", stall_cnt_o, 16'd5);
      rst = 1'b1;
      #1 chk("rst2_in_ready", in_ready, 1'b0);
      step();
      chk("rst2_valid", out_valid, 1'b0);
      chk("rst2_stall", stall_cnt_o, 16'd0);
      chk("rst2_reg1", reg1_o, 32'h0);
      rst = 1'b0; in_valid = 1'b0; clr_fwd();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
